// File: rtl/wts_pkg.sv
// Shared definitions for the wave-table synth envelope path.
//   env_state_t : ADSR phase encoding used by the envelope generator
//   ENV_BITS    : envelope width
//   ENV_MAX     : envelope full scale (2**ENV_BITS-1)
//   RATE_BITS   : width of rate registers and rate prescalers
package wts_pkg;

    localparam int ENV_BITS  = 7;
    localparam int ENV_MAX   = (1 << ENV_BITS) - 1;
    localparam int RATE_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

endpackage

// File: rtl/wts_rate_counter.sv
// Rate prescaler: emits one step per `load` enabled cycles.
//   clk    : system clock
//   nreset : asynchronous active-low reset, clears the count
//   load   : reload value (rate); 0 freezes the counter and suppresses steps
//   clear  : force count to 0 so the next enabled cycle steps (wins over enable)
//   enable : advance this cycle (an update slot)
//   step   : combinational, high on an enabled cycle whose count is 0
// The reload value is only sampled when the count wraps, so a rate change
// never truncates a running interval.
module wts_rate_counter
    import wts_pkg::*;
#(
    parameter int WIDTH = RATE_BITS
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] load,
    input  logic             clear,
    input  logic             enable,
    output logic             step
);

    logic [WIDTH-1:0] count;
    logic             run;

    assign run  = enable && (load != '0);
    assign step = run && (count == '0);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            if (count == '0) count <= load - WIDTH'(1);
            else             count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/wts_envelope_generator.sv
// Per-channel ADSR envelope generator feeding the channel volume stage.
//   clk      : system clock (21.477 MHz), all state on rising edge
//   nreset   : asynchronous active-low reset
//   active   : one-cycle pulse per envelope update slot
//   key_on   : 1 = note held, 0 = released
//   reg_ar   : attack rate  (one step per reg_ar slots, 0 = frozen)
//   reg_dr   : decay rate
//   reg_sl   : sustain level, decay target = {reg_sl,3'b000}
//   reg_sr   : sustain-phase decay rate
//   reg_rr   : release rate
//   envelope : current level, registered
//   env_busy : high whenever the phase is not IDLE
module wts_envelope_generator
    import wts_pkg::*;
#(
    parameter int ENV_BITS  = 7,
    parameter int RATE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 active,
    input  logic                 key_on,
    input  logic [RATE_BITS-1:0] reg_ar,
    input  logic [RATE_BITS-1:0] reg_dr,
    input  logic [3:0]           reg_sl,
    input  logic [RATE_BITS-1:0] reg_sr,
    input  logic [RATE_BITS-1:0] reg_rr,
    output logic [ENV_BITS-1:0]  envelope,
    output logic                 env_busy
);

    localparam logic [ENV_BITS-1:0] ENV_TOP = ENV_BITS'((1 << ENV_BITS) - 1);

    env_state_t           state, state_next;
    logic [ENV_BITS-1:0]  env_next;
    logic [ENV_BITS-1:0]  target;
    logic [RATE_BITS-1:0] rate;
    logic                 key_on_d;
    logic                 rise, fall, fall_eff;
    logic                 step, phase_done, clear, enable;

    assign rise     = key_on && !key_on_d;
    assign fall     = !key_on && key_on_d;
    // A release only means something while the note is sounding.
    assign fall_eff = fall && (state inside {ATTACK, DECAY, SUSTAIN});
    assign target   = ENV_BITS'({reg_sl, 3'b000});

    // Key edges pre-empt any step due in the same cycle.
    assign enable = active && !rise && !fall_eff;
    assign clear  = rise || fall_eff || phase_done;

    always_comb begin
        rate = '0;
        case (state)
            ATTACK:  rate = reg_ar;
            DECAY:   rate = reg_dr;
            SUSTAIN: rate = reg_sr;
            RELEASE: rate = reg_rr;
            default: rate = '0;
        endcase
    end

    wts_rate_counter #(
        .WIDTH (RATE_BITS)
    ) u_rate (
        .clk    (clk),
        .nreset (nreset),
        .load   (rate),
        .clear  (clear),
        .enable (enable),
        .step   (step)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            key_on_d <= 1'b0;
        end else begin
            state    <= state_next;
            key_on_d <= key_on;
        end
    end

    always_comb begin
        state_next = state;
        env_next   = envelope;
        phase_done = 1'b0;
        if (rise) begin
            // Attack restarts from wherever the level currently is.
            state_next = ATTACK;
        end else if (fall_eff) begin
            state_next = RELEASE;
        end else if (step) begin
            case (state)
                ATTACK: begin
                    env_next = (envelope == ENV_TOP) ? ENV_TOP : envelope + ENV_BITS'(1);
                    if (env_next == ENV_TOP) begin
                        state_next = DECAY;
                        phase_done = 1'b1;
                    end
                end
                DECAY: begin
                    // Reaching the target costs one step with no level change.
                    if (envelope <= target) begin
                        state_next = SUSTAIN;
                        phase_done = 1'b1;
                    end else begin
                        env_next = envelope - ENV_BITS'(1);
                    end
                end
                SUSTAIN, RELEASE: begin
                    env_next = (envelope == '0) ? '0 : envelope - ENV_BITS'(1);
                    if (env_next == '0) state_next = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) envelope <= '0;
        else         envelope <= env_next;
    end

    always_comb begin
        env_busy = (state != IDLE);
    end

endmodule

// File: tb/tb_wts_envelope_generator.sv
module tb_wts_envelope_generator;

    localparam int S_IDLE = 0, S_ATK = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic       clk    = 1'b0;
    logic       nreset = 1'b1;
    logic       active = 1'b0;
    logic       key_on = 1'b0;
    logic [7:0] reg_ar = '0, reg_dr = '0, reg_sr = '0, reg_rr = '0;
    logic [3:0] reg_sl = '0;
    logic [6:0] envelope;
    logic       env_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase, level, slots left until the next step, last key.
    int m_state, m_env, m_pre;
    bit m_kd;

    wts_envelope_generator #(.ENV_BITS(7), .RATE_BITS(8)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .active   (active),
        .key_on   (key_on),
        .reg_ar   (reg_ar),
        .reg_dr   (reg_dr),
        .reg_sl   (reg_sl),
        .reg_sr   (reg_sr),
        .reg_rr   (reg_rr),
        .envelope (envelope),
        .env_busy (env_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = S_IDLE;
        m_env   = 0;
        m_pre   = 0;
        m_kd    = 0;
    endfunction

    function automatic int model_rate();
        case (m_state)
            S_ATK:   return int'(reg_ar);
            S_DEC:   return int'(reg_dr);
            S_SUS:   return int'(reg_sr);
            S_REL:   return int'(reg_rr);
            default: return 0;
        endcase
    endfunction

    function automatic void model_edge();
        bit rise, fall;
        int r;
        rise = key_on && !m_kd;
        fall = !key_on && m_kd;
        m_kd = key_on;
        r    = model_rate();
        if (rise) begin
            m_state = S_ATK;
            m_pre   = 0;
        end else if (fall && (m_state == S_ATK || m_state == S_DEC || m_state == S_SUS)) begin
            m_state = S_REL;
            m_pre   = 0;
        end else if (active && r != 0) begin
            if (m_pre > 0) begin
                m_pre--;
            end else begin
                m_pre = r - 1;
                case (m_state)
                    S_ATK: begin
                        if (m_env < 127) m_env++;
                        if (m_env == 127) begin m_state = S_DEC; m_pre = 0; end
                    end
                    S_DEC: begin
                        if (m_env <= int'(reg_sl) * 8) begin m_state = S_SUS; m_pre = 0; end
                        else m_env--;
                    end
                    S_SUS, S_REL: begin
                        if (m_env > 0) m_env--;
                        if (m_env == 0) m_state = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, check at negedge.
    task automatic tick(input bit a, input bit k);
        active = a;
        key_on = k;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("env", int'(envelope), m_env);
        chk("busy", int'(env_busy), int'(m_state != S_IDLE));
    endtask

    task automatic pulses(input int n, input int gap, input bit k);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, k);
            for (int j = 1; j < gap; j++) tick(1'b0, k);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic do_reset();
        #2 nreset = 1'b0;
        key_on = 1'b0;
        active = 1'b0;
        #1;
        model_reset();
        chk("rst_env", int'(envelope), 0);
        chk("rst_busy", int'(env_busy), 0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        bit kon;
        model_reset();
        #1 nreset = 1'b0;
        #1;
        chk("por_env", int'(envelope), 0);
        chk("por_busy", int'(env_busy), 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        // Full attack, decay to sustain 64, hold, release to idle.
        reg_ar = 8'd1; reg_dr = 8'd2; reg_sl = 4'd8; reg_sr = 8'd0; reg_rr = 8'd1;
        tick(1'b0, 1'b1);
        pulses(127, 4, 1'b1);
        chk("atk_full", int'(envelope), 127);
        chk("atk_busy", int'(env_busy), 1);
        pulses(200, 4, 1'b1);
        chk("sus_hold", int'(envelope), 64);
        pulses(50, 2, 1'b1);
        chk("sus_hold2", int'(envelope), 64);
        tick(1'b0, 1'b0);
        pulses(63, 2, 1'b0);
        chk("rel_63", int'(envelope), 1);
        chk("rel_busy", int'(env_busy), 1);
        pulses(1, 2, 1'b0);
        chk("rel_zero", int'(envelope), 0);
        chk("rel_idle", int'(env_busy), 0);

        // Re-key during release at level 40 with a slot in the same cycle.
        tick(1'b0, 1'b1);
        pulses(127, 2, 1'b1);
        pulses(140, 2, 1'b1);
        tick(1'b0, 1'b0);
        pulses(24, 1, 1'b0);
        chk("rel_40", int'(envelope), 40);
        tick(1'b1, 1'b1);
        chk("rekey_hold", int'(envelope), 40);
        chk("rekey_busy", int'(env_busy), 1);
        tick(1'b1, 1'b1);
        chk("rekey_step", int'(envelope), 41);

        // Attack rate 0 freezes the level.
        do_reset();
        reg_ar = 8'd0;
        tick(1'b0, 1'b1);
        pulses(200, 2, 1'b1);
        chk("ar0_env", int'(envelope), 0);
        chk("ar0_busy", int'(env_busy), 1);

        // Reset mid-attack, then stay idle until a new key rise.
        reg_ar = 8'd1;
        pulses(90, 2, 1'b1);
        chk("atk_90", int'(envelope), 90);
        do_reset();
        pulses(20, 2, 1'b0);
        chk("post_rst_idle", int'(env_busy), 0);
        chk("post_rst_env", int'(envelope), 0);
        tick(1'b0, 1'b1);
        chk("post_rst_key", int'(env_busy), 1);

        // Randomized operation against the model.
        kon = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                reg_ar = 8'($urandom_range(0, 3));
                reg_dr = 8'($urandom_range(0, 3));
                reg_sr = 8'($urandom_range(0, 3));
                reg_rr = 8'($urandom_range(0, 3));
                reg_sl = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 299) == 0) kon = !kon;
            if ($urandom_range(0, 2499) == 0) do_reset();
            tick(1'($urandom_range(0, 3) != 0), kon);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
